// File: rtl/lap_pkg.sv
// lap_pkg: shared widths, state encoding and constants for the lap recorder.
package lap_pkg;
  localparam int DIGITS = 8;
  localparam int BCD_W = 4;
  localparam int TIME_W = DIGITS * BCD_W;
  localparam logic [TIME_W-1:0] TIME_ZERO = '0;
  typedef enum logic {ST_LIVE, ST_RECALL} state_t;
endpackage

// File: rtl/toggle_edge.sv
// toggle_edge: turns a toggle-level key into a one-cycle press pulse on every level change.
module toggle_edge (
  input  logic clk,
  input  logic reset,
  input  logic tgl,
  output logic press
);
  logic prev_q;
  // prev tracks the input even in reset, so the level present at release is never seen as a press
  always_ff @(posedge clk) prev_q <= tgl;
  assign press = ~reset & (tgl ^ prev_q);
endmodule

// File: rtl/lap_recorder.sv
// lap_recorder: stores lap snapshots of the live BCD time and selects live or recalled time for display.
module lap_recorder
  import lap_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HOLD_CYCLES = 2**24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TIME_W-1:0] time_bcd,
  input  logic              lap_tgl,
  input  logic              recall_tgl,
  input  logic              clear_tgl,
  output logic [TIME_W-1:0] disp_bcd,
  output logic              recall_mode,
  output logic [3:0]        lap_idx,
  output logic [4:0]        lap_count,
  output logic              full,
  output logic              overflow
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int HW = HOLD_CYCLES > 2 ? $clog2(HOLD_CYCLES) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic ovf_q, ovf_d;
  logic [TIME_W-1:0] disp_q, disp_d;
  logic [TIME_W-1:0] mem_q [DEPTH];
  logic lap_p, rec_p, clr_p, lap_wr, timeout, last;
  toggle_edge u_lap (.clk(clk), .reset(reset), .tgl(lap_tgl), .press(lap_p));
  toggle_edge u_rec (.clk(clk), .reset(reset), .tgl(recall_tgl), .press(rec_p));
  toggle_edge u_clr (.clk(clk), .reset(reset), .tgl(clear_tgl), .press(clr_p));
  assign full = cnt_q == CW'(DEPTH);
  assign recall_mode = state_q == ST_RECALL;
  assign lap_wr = lap_p & ~full & ~clr_p;
  assign timeout = hold_q == HW'(HOLD_CYCLES - 1);
  assign last = CW'(idx_q) == cnt_q - 1'b1;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    hold_d = recall_mode ? hold_q + 1'b1 : '0;
    cnt_d = cnt_q + CW'(lap_wr);
    ovf_d = ovf_q | (lap_p & full);
    disp_d = recall_mode ? mem_q[idx_q] : time_bcd;
    if (recall_mode && timeout) begin
      state_d = ST_LIVE;
      idx_d = '0;
      hold_d = '0;
    end
    // recall decisions use the lap count from before any same-cycle write
    if (rec_p) begin
      if (!recall_mode) begin
        state_d = cnt_q != '0 ? ST_RECALL : ST_LIVE;
        idx_d = '0;
        hold_d = '0;
      end else begin
        state_d = last ? ST_LIVE : ST_RECALL;
        idx_d = last ? '0 : idx_q + 1'b1;
        hold_d = '0;
      end
    end
    if (clr_p) begin
      state_d = ST_LIVE;
      idx_d = '0;
      hold_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LIVE;
      idx_q <= '0;
      cnt_q <= '0;
      hold_q <= '0;
      ovf_q <= 1'b0;
      disp_q <= TIME_ZERO;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      ovf_q <= ovf_d;
      disp_q <= disp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && lap_wr) mem_q[cnt_q[IW-1:0]] <= time_bcd;
  end
  assign disp_bcd = disp_q;
  assign lap_idx = 4'(idx_q);
  assign lap_count = 5'(cnt_q);
  assign overflow = ovf_q;
endmodule

// File: tb/tb_lap_recorder.sv
// tb_lap_recorder: directed stimulus with a queue-based lap model checked every cycle plus literal spot checks.
module tb_lap_recorder;
  localparam int DEPTH = 8;
  localparam int HOLD = 16;
  logic clk = 0, reset = 1;
  logic [31:0] time_bcd = '0;
  logic lap_tgl = 1, recall_tgl = 0, clear_tgl = 0;
  logic [31:0] disp_bcd;
  logic recall_mode, full, overflow;
  logic [3:0] lap_idx;
  logic [4:0] lap_count;
  int vectors = 0, miscompares = 0;
  bit chk = 0;
  lap_recorder #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .time_bcd(time_bcd), .lap_tgl(lap_tgl),
    .recall_tgl(recall_tgl), .clear_tgl(clear_tgl), .disp_bcd(disp_bcd),
    .recall_mode(recall_mode), .lap_idx(lap_idx), .lap_count(lap_count),
    .full(full), .overflow(overflow)
  );
  always #5 clk = ~clk;
  logic [31:0] m_laps [$];
  logic [31:0] m_disp, nxt;
  bit m_rec, m_ovf, p_lap, p_rec, p_clr, lp, rp, cp;
  int m_idx, m_idle, n;
  always @(posedge clk) begin
    if (reset) begin
      m_laps.delete();
      m_rec = 0; m_idx = 0; m_idle = 0; m_ovf = 0; m_disp = '0;
    end else begin
      lp = lap_tgl != p_lap; rp = recall_tgl != p_rec; cp = clear_tgl != p_clr;
      nxt = m_rec ? m_laps[m_idx] : time_bcd;
      n = m_laps.size();
      if (cp) begin
        m_laps.delete();
        m_rec = 0; m_idx = 0; m_idle = 0; m_ovf = 0;
      end else begin
        if (lp) begin
          if (n < DEPTH) m_laps.push_back(time_bcd);
          else m_ovf = 1;
        end
        if (rp) begin
          if (!m_rec) begin
            if (n > 0) begin m_rec = 1; m_idx = 0; m_idle = 0; end
          end else if (m_idx == n - 1) begin
            m_rec = 0; m_idx = 0;
          end else begin
            m_idx++; m_idle = 0;
          end
        end else if (m_rec) begin
          if (m_idle == HOLD - 1) begin m_rec = 0; m_idx = 0; m_idle = 0; end
          else m_idle++;
        end
      end
      m_disp = nxt;
    end
    p_lap = lap_tgl; p_rec = recall_tgl; p_clr = clear_tgl;
  end
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk) begin
    cmp("m.disp_bcd", disp_bcd, m_disp);
    cmp("m.recall_mode", {31'b0, recall_mode}, {31'b0, m_rec});
    cmp("m.lap_idx", {28'b0, lap_idx}, m_idx);
    cmp("m.lap_count", {27'b0, lap_count}, m_laps.size());
    cmp("m.full", {31'b0, full}, {31'b0, m_laps.size() == DEPTH});
    cmp("m.overflow", {31'b0, overflow}, {31'b0, m_ovf});
  end
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic lap(input logic [31:0] t);
    time_bcd = t; lap_tgl = ~lap_tgl; tick(1);
  endtask
  task automatic rec();
    recall_tgl = ~recall_tgl; tick(1);
  endtask
  task automatic clr();
    clear_tgl = ~clear_tgl; tick(1);
  endtask
  initial begin
    tick(2);
    chk = 1;
    cmp("rst.lap_count", {27'b0, lap_count}, 0);
    cmp("rst.disp", disp_bcd, 32'h0);
    reset = 0; time_bcd = 32'h01234567;
    tick(1);
    cmp("live.disp", disp_bcd, 32'h01234567);
    cmp("live.no_press", {27'b0, lap_count}, 0);
    lap(32'h00001234); lap(32'h00002500); lap(32'h00013007);
    cmp("laps3.count", {27'b0, lap_count}, 3);
    rec(); cmp("rec0.mode", {31'b0, recall_mode}, 1);
    tick(1); cmp("rec0.disp", disp_bcd, 32'h00001234);
    rec(); tick(1); cmp("rec1.disp", disp_bcd, 32'h00002500);
    rec(); tick(1); cmp("rec2.disp", disp_bcd, 32'h00013007);
    cmp("rec2.idx", {28'b0, lap_idx}, 2);
    time_bcd = 32'h00020000;
    rec(); cmp("rec3.mode", {31'b0, recall_mode}, 0);
    tick(1); cmp("rec3.disp", disp_bcd, 32'h00020000);
    clr(); cmp("clr.count", {27'b0, lap_count}, 0);
    for (int i = 1; i <= 8; i++) lap(32'h00100000 + i);
    cmp("fill.full", {31'b0, full}, 1);
    cmp("fill.ovf", {31'b0, overflow}, 0);
    lap(32'h00999999);
    cmp("ovf.count", {27'b0, lap_count}, 8);
    cmp("ovf.ovf", {31'b0, overflow}, 1);
    rec();
    for (int i = 0; i < 7; i++) rec();
    tick(1);
    cmp("mem7.disp", disp_bcd, 32'h00100008);
    rec(); cmp("mem7.exit", {31'b0, recall_mode}, 0);
    clr();
    cmp("clr2.count", {27'b0, lap_count}, 0);
    cmp("clr2.ovf", {31'b0, overflow}, 0);
    cmp("clr2.full", {31'b0, full}, 0);
    lap(32'h00030000); lap(32'h00040000);
    rec();
    tick(15); cmp("hold15.mode", {31'b0, recall_mode}, 1);
    tick(1); cmp("hold16.mode", {31'b0, recall_mode}, 0);
    rec();
    tick(15); rec();
    cmp("holdpress.mode", {31'b0, recall_mode}, 1);
    cmp("holdpress.idx", {28'b0, lap_idx}, 1);
    tick(15); cmp("hold2_15.mode", {31'b0, recall_mode}, 1);
    tick(1); cmp("hold2_16.mode", {31'b0, recall_mode}, 0);
    clr();
    time_bcd = 32'h00050000; lap_tgl = ~lap_tgl; recall_tgl = ~recall_tgl; tick(1);
    cmp("same.count", {27'b0, lap_count}, 1);
    cmp("same.mode", {31'b0, recall_mode}, 0);
    lap(32'h00060000);
    time_bcd = 32'h00070000; lap_tgl = ~lap_tgl; clear_tgl = ~clear_tgl; tick(1);
    cmp("clrlap.count", {27'b0, lap_count}, 0);
    lap(32'h00080000);
    rec(); cmp("prerst.mode", {31'b0, recall_mode}, 1);
    reset = 1; tick(1);
    cmp("rst2.mode", {31'b0, recall_mode}, 0);
    cmp("rst2.count", {27'b0, lap_count}, 0);
    reset = 0; tick(3);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
